seq_nr_divider: RTL and testbench



---
 rtl/div_pkg.sv | 26 ++
 rtl/div_nr_step.sv | 31 +++
 rtl/seq_nr_divider.sv | 162 ++++++++++++++++
 tb/tb_seq_nr_divider.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared constants and types for the sequential non-restoring divider.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package div_pkg;

   localparam int DIVD_W = 32;                 // dividend width
   localparam int DIVS_W = 16;                 // divisor / quotient / remainder width
   localparam int ITER_N = 16;                 // one quotient bit per iteration
   localparam int CNT_W  = $clog2(ITER_N);

   // Counter is loaded with the last index and counts down to zero.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_N - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_ITER,
      S_FIX,
      S_DONE
   } div_state_t;

   // Result presented when the quotient cannot be represented.
   localparam logic [DIVS_W-1:0] OVF_QUOT = {DIVS_W{1'b1}};
   localparam logic [DIVS_W-1:0] OVF_REM  = {DIVS_W{1'b0}};

endpackage

// File: rtl/div_nr_step.sv
// One non-restoring step: shift {P,Q} left, add or subtract divisor by sign of P.
// Latency: combinational, 0 cycles.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   p_i / p_o : 17-bit two's complement partial remainder, before / after
//   q_i / q_o : 16-bit quotient shift register, before / after
//   d_i       : 16-bit unsigned divisor
module div_nr_step
   import div_pkg::*;
(
   input  logic [DIVS_W:0]   p_i,
   input  logic [DIVS_W-1:0] q_i,
   input  logic [DIVS_W-1:0] d_i,
   output logic [DIVS_W:0]   p_o,
   output logic [DIVS_W-1:0] q_o
);

   logic [DIVS_W:0] p_sh;
   logic [DIVS_W:0] d_ext;

   assign p_sh  = {p_i[DIVS_W-1:0], q_i[DIVS_W-1]};
   assign d_ext = {1'b0, d_i};

   // The shifted value may need 18 bits, but the post-add/sub result always
   // lies in [-D, D) and fits 17 bits, so modulo-2^17 arithmetic is exact.
   // The add/sub decision therefore uses the sign of the un-shifted P.
   assign p_o = p_i[DIVS_W] ? (p_sh + d_ext) : (p_sh - d_ext);
   assign q_o = {q_i[DIVS_W-2:0], ~p_o[DIVS_W]};

endmodule

// File: rtl/seq_nr_divider.sv
// Radix-2 non-restoring divider, 32/16 -> 16-bit quotient and remainder.
// Latency: done 19 cycles after the accepting edge, 2 cycles on overflow.
// Backpressure: start is ignored while busy; a start in the done cycle is accepted.
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start               : request, accepted only in IDLE or DONE
//   dividend, divisor   : operands, captured on an accepted start
//   busy                : high in CHECK, ITER and FIX
//   done                : one-cycle result-valid pulse
//   quotient, remainder : result, held until the next result
//   ovf                 : divisor zero or quotient unrepresentable
// Build option: DIV_SIGNED_EN selects two's complement operands.
module seq_nr_divider
   import div_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DIVD_W-1:0] dividend,
   input  logic [DIVS_W-1:0] divisor,
   output logic              busy,
   output logic              done,
   output logic [DIVS_W-1:0] quotient,
   output logic [DIVS_W-1:0] remainder,
   output logic              ovf
);

   div_state_t        state_q;
   logic [DIVD_W-1:0] divd_q;      // dividend magnitude
   logic [DIVS_W-1:0] divs_q;      // divisor magnitude
   logic [DIVS_W:0]   p_q;
   logic [DIVS_W-1:0] q_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              busy_q;
   logic              done_q;
   logic              ovf_q;
   logic [DIVS_W-1:0] quot_q;
   logic [DIVS_W-1:0] rem_q;
`ifdef DIV_SIGNED_EN
   logic              qneg_q;      // quotient sign
   logic              rneg_q;      // remainder follows dividend sign
`endif

   logic [DIVS_W:0]   p_d;
   logic [DIVS_W-1:0] q_d;
   logic [DIVD_W-1:0] divd_mag_d;
   logic [DIVS_W-1:0] divs_mag_d;
   logic [DIVS_W-1:0] rem_fix;
   logic [DIVS_W-1:0] fix_quot_d;
   logic [DIVS_W-1:0] fix_rem_d;
   logic              fix_ovf_d;

   div_nr_step u_step (
      .p_i (p_q),
      .q_i (q_q),
      .d_i (divs_q),
      .p_o (p_d),
      .q_o (q_d)
   );

   always_comb begin
      divd_mag_d = dividend;
      divs_mag_d = divisor;
      // Final remainder lies in [0, D), so 16-bit wrap-around is exact.
      rem_fix    = p_q[DIVS_W] ? (p_q[DIVS_W-1:0] + divs_q) : p_q[DIVS_W-1:0];
      fix_quot_d = q_q;
      fix_rem_d  = rem_fix;
      fix_ovf_d  = 1'b0;
`ifdef DIV_SIGNED_EN
      if (dividend[DIVD_W-1]) divd_mag_d = -dividend;
      if (divisor[DIVS_W-1])  divs_mag_d = -divisor;
      // Negative results may reach -32768, positive only +32767.
      if (qneg_q) begin
         fix_ovf_d  = (q_q > 16'h8000);
         fix_quot_d = -q_q;
      end else begin
         fix_ovf_d  = (q_q > 16'h7FFF);
      end
      if (rneg_q) fix_rem_d = -rem_fix;
      if (fix_ovf_d) begin
         fix_quot_d = OVF_QUOT;
         fix_rem_d  = OVF_REM;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         divd_q  <= '0;
         divs_q  <= '0;
         p_q     <= '0;
         q_q     <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
         quot_q  <= '0;
         rem_q   <= '0;
`ifdef DIV_SIGNED_EN
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  divd_q  <= divd_mag_d;
                  divs_q  <= divs_mag_d;
`ifdef DIV_SIGNED_EN
                  qneg_q  <= dividend[DIVD_W-1] ^ divisor[DIVS_W-1];
                  rneg_q  <= dividend[DIVD_W-1];
`endif
                  busy_q  <= 1'b1;
                  state_q <= S_CHECK;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_CHECK: begin
               if ((divs_q == '0) || (divd_q[DIVD_W-1:DIVS_W] >= divs_q)) begin
                  quot_q  <= OVF_QUOT;
                  rem_q   <= OVF_REM;
                  ovf_q   <= 1'b1;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  p_q     <= {1'b0, divd_q[DIVD_W-1:DIVS_W]};
                  q_q     <= divd_q[DIVS_W-1:0];
                  cnt_q   <= CNT_LAST;
                  state_q <= S_ITER;
               end
            end
            S_ITER: begin
               p_q   <= p_d;
               q_q   <= q_d;
               cnt_q <= cnt_q - CNT_W'(1);
               if (cnt_q == '0) state_q <= S_FIX;
            end
            S_FIX: begin
               quot_q  <= fix_quot_d;
               rem_q   <= fix_rem_d;
               ovf_q   <= fix_ovf_d;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               state_q <= S_DONE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign ovf       = ovf_q;
   assign quotient  = quot_q;
   assign remainder = rem_q;

endmodule

// File: tb/tb_seq_nr_divider.sv
// Scoreboard bench for seq_nr_divider: directed vectors, decoupled monitor.
// Latency: checks the done cycle of every accepted operation.
// Backpressure: exercises ignored start while busy and start in the done cycle.
module tb_seq_nr_divider;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] dividend;
   logic [15:0] divisor;
   logic        busy;
   logic        done;
   logic [15:0] quotient;
   logic [15:0] remainder;
   logic        ovf;

   typedef struct {
      logic [15:0] q;
      logic [15:0] r;
      logic        o;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   cyc   = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   seq_nr_divider dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, want, cyc);
      end
   endtask

   // Monitor: pops one expectation per done pulse.
   always @(negedge clk) begin
      if (!reset && done) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL spurious_done: got done=1, want no pending result (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("quotient",  {16'h0, quotient},  {16'h0, e.q});
            chk("remainder", {16'h0, remainder}, {16'h0, e.r});
            chk("ovf",       {31'h0, ovf},       {31'h0, e.o});
            chk("done_cycle", cyc, e.cyc);
            chk("busy_in_done", {31'h0, busy}, 32'h0);
         end
      end
   end

   // Drive start for one edge; returns the cycle index of the accepting edge.
   task automatic pulse(input logic [31:0] dvd, input logic [15:0] dvs, output int acc);
      dividend = dvd;
      divisor  = dvs;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      acc   = cyc;
   endtask

   // done is visible lat-1 edges after the accepting edge (CHECK is cycle 1).
   task automatic issue(input logic [31:0] dvd, input logic [15:0] dvs,
                        input logic [15:0] eq, input logic [15:0] er,
                        input logic eo, input int lat);
      int acc;
      pulse(dvd, dvs, acc);
      sb.push_back('{eq, er, eo, acc + lat - 1});
   endtask

   task automatic wait_done;
      bit seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(posedge clk);
         #1;
         if (done) seen = 1'b1;
      end
      if (!seen) begin
         n_cmp++;
         n_err++;
         $display("FAIL done_timeout: got no done in 40 cycles, want done");
      end
   endtask

   task automatic run(input logic [31:0] dvd, input logic [15:0] dvs,
                      input logic [15:0] eq, input logic [15:0] er,
                      input logic eo, input int lat);
      issue(dvd, dvs, eq, er, eo, lat);
      wait_done();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got simulation still running, want finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      reset    = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_done", {31'h0, done}, 32'h0);
      chk("rst_ovf",  {31'h0, ovf},  32'h0);
      chk("rst_quot", {16'h0, quotient},  32'h0);
      chk("rst_rem",  {16'h0, remainder}, 32'h0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Basic and overflow vectors.
      run(32'h000186A0, 16'h03E8, 16'd100, 16'd0, 1'b0, 19);
      run(32'h00001234, 16'h0000, 16'hFFFF, 16'h0000, 1'b1, 2);
      run(32'h00050000, 16'h0005, 16'hFFFF, 16'h0000, 1'b1, 2);
      run(32'd1000, 16'd7, 16'd142, 16'd6, 1'b0, 19);
`ifdef DIV_SIGNED_EN
      run(32'hFFFFFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 19);
      run(32'h80000000, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 2);
`else
      run(32'hFFFE0001, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 19);
      for (int x = 0; x <= 65535; x += 5000) begin
         for (int y = 5000; y <= 65535; y += 5000) begin
            longint unsigned dv;
            dv = longint'(x) * longint'(y) + longint'(y - 1);
            run(dv[31:0], y[15:0], x[15:0], 16'(y - 1), 1'b0, 19);
         end
      end
`endif

      // Start while busy is ignored; start in the done cycle is accepted.
      issue(32'd1000, 16'd7, 16'd142, 16'd6, 1'b0, 19);
      repeat (7) @(posedge clk);
      #1;
      pulse(32'd5000, 16'd3, acc);
      chk("busy_after_ignored_start", {31'h0, busy}, 32'h1);
      wait_done();
      run(32'd60000, 16'd300, 16'd200, 16'd0, 1'b0, 19);

      // Reset mid-operation: outputs cleared, no done follows.
      pulse(32'h000186A0, 16'h03E8, acc);
      repeat (7) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("midrst_busy", {31'h0, busy}, 32'h0);
      chk("midrst_done", {31'h0, done}, 32'h0);
      chk("midrst_ovf",  {31'h0, ovf},  32'h0);
      chk("midrst_quot", {16'h0, quotient},  32'h0);
      chk("midrst_rem",  {16'h0, remainder}, 32'h0);
      repeat (25) @(posedge clk);
      #1;
      run(32'd1000, 16'd7, 16'd142, 16'd6, 1'b0, 19);

      repeat (5) @(posedge clk);
      #1;
      chk("scoreboard_empty", sb.size(), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
